stream_fifo: RTL

- Synchronous ready/valid byte FIFO sitting directly upstream of the ready/valid consumer stage.
- Its m_* side drives the consumer's valid_i/data_i and honours the consumer's ready_o; one instance per consumer channel (vip_test and kelvin).
- Decouples producer burstiness from consumer back-pressure.
- Reports occupancy, full/empty and a sticky high-water mark for the testbench scoreboard.

---
 rtl/stream_fifo.sv | 105 ++++++++++
 1 files changed

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - ready/valid byte FIFO with occupancy, flags and sticky high-water mark
module stream_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  high_water_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = DEPTH;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  high_water_q, high_water_d;
    logic              s_ready_q, s_ready_d;
    logic              m_valid_q, m_valid_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push, pop;

    // Handshakes use only registered flags, so m_ready_i never reaches s_ready_o.
    assign push = s_valid_i & s_ready_q;
    assign pop  = m_valid_q & m_ready_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = s_data_i;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
        full_d       = (count_d == CNT_MAX);
        empty_d      = (count_d == '0);
        s_ready_d    = !full_d;
        m_valid_d    = !empty_d;
        high_water_d = (count_d > high_water_q) ? count_d : high_water_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            high_water_q <= '0;
            s_ready_q    <= 1'b1;
            m_valid_q    <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            high_water_q <= high_water_d;
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
        end
    end

    assign s_ready_o    = s_ready_q;
    assign m_valid_o    = m_valid_q;
    assign m_data_o     = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign high_water_o = high_water_q;

endmodule
